// File: rtl/button_event_decoder.sv
// rtl/button_event_decoder.sv - push-button gesture classifier (short, double, long, optional auto-repeat via AUTO_REPEAT_EN)
module button_event_decoder #(
  parameter int LONG_TICKS   = 500,
  parameter int DCLICK_TICKS = 250,
  parameter int REPEAT_TICKS = 100,
  parameter int CNT_W        = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_tick,
  input  logic i_pb_state,
  input  logic i_pb_down,
  input  logic i_pb_up,
  output logic o_short_press,
  output logic o_double_click,
  output logic o_long_press,
  output logic o_repeat,
  output logic o_held_long,
  output logic o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_WAIT_SECOND,
    S_SECOND_PRESSED,
    S_LONG_HELD
  } state_t;

  localparam logic [CNT_W-1:0] LP_LONG_LAST   = CNT_W'(LONG_TICKS - 1);
  localparam logic [CNT_W-1:0] LP_DCLICK_LAST = CNT_W'(DCLICK_TICKS - 1);

  // Reject parameter sets that would let a threshold be skipped or the counter wrap
  if (LONG_TICKS < 2) begin : g_bad_long
    $error("LONG_TICKS must be >= 2");
  end
  if (DCLICK_TICKS < 1) begin : g_bad_dclick
    $error("DCLICK_TICKS must be >= 1");
  end
  if (REPEAT_TICKS < 1) begin : g_bad_repeat
    $error("REPEAT_TICKS must be >= 1");
  end
  if ((LONG_TICKS > (2 ** CNT_W) - 1) || (DCLICK_TICKS > (2 ** CNT_W) - 1) ||
      (REPEAT_TICKS > (2 ** CNT_W) - 1)) begin : g_bad_cnt_w
    $error("CNT_W too small for the tick thresholds");
  end

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic             r_short_press;
  logic             r_double_click;
  logic             r_long_press;
  logic             w_short_next;
  logic             w_double_next;
  logic             w_long_next;
  logic             w_repeat_next;
  logic             w_reload;
  logic             w_count_en;

  // Simultaneous down/up is a protocol error, so both qualified pulses drop out
  logic w_down;
  logic w_up;
  logic w_lost;
  assign w_down = i_pb_down & ~i_pb_up;
  assign w_up   = i_pb_up & ~i_pb_down;
  // Button reads released but the release pulse never arrived
  assign w_lost = ~i_pb_state & ~i_pb_up;

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] LP_REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
  logic r_repeat;
  assign w_count_en = (r_state != S_IDLE);
`else
  assign w_count_en = (r_state != S_IDLE) && (r_state != S_LONG_HELD);
`endif

  // Next-state and event decode; release/press always wins over a coincident timer tick
  always_comb begin
    w_state_next  = r_state;
    w_short_next  = 1'b0;
    w_double_next = 1'b0;
    w_long_next   = 1'b0;
    w_repeat_next = 1'b0;
    w_reload      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_down) w_state_next = S_PRESSED;
      end
      S_PRESSED: begin
        if (w_up) begin
          w_state_next = S_WAIT_SECOND;
        end else if (w_lost) begin
          w_state_next = S_IDLE;
        end else if (i_tick && (r_cnt == LP_LONG_LAST)) begin
          w_long_next  = 1'b1;
          w_state_next = S_LONG_HELD;
        end
      end
      S_WAIT_SECOND: begin
        if (w_down) begin
          w_state_next = S_SECOND_PRESSED;
        end else if (i_tick && (r_cnt == LP_DCLICK_LAST)) begin
          w_short_next = 1'b1;
          w_state_next = S_IDLE;
        end
      end
      S_SECOND_PRESSED: begin
        if (w_up) begin
          w_double_next = 1'b1;
          w_state_next  = S_IDLE;
        end else if (w_lost) begin
          w_state_next = S_IDLE;
        end else if (i_tick && (r_cnt == LP_LONG_LAST)) begin
          w_long_next  = 1'b1;
          w_state_next = S_LONG_HELD;
        end
      end
      S_LONG_HELD: begin
        if (w_up || w_lost) begin
          w_state_next = S_IDLE;
        end
`ifdef AUTO_REPEAT_EN
        else if (i_tick && (r_cnt == LP_REPEAT_LAST)) begin
          w_repeat_next = 1'b1;
          w_reload      = 1'b1;
        end
`endif
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // Tick counter: cleared on every state change or reload, idle in IDLE
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if ((w_state_next != r_state) || w_reload || !w_count_en) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Registered one-cycle event pulses
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_short_press  <= 1'b0;
      r_double_click <= 1'b0;
      r_long_press   <= 1'b0;
    end else begin
      r_short_press  <= w_short_next;
      r_double_click <= w_double_next;
      r_long_press   <= w_long_next;
    end
  end

`ifdef AUTO_REPEAT_EN
  // Registered auto-repeat pulse
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_repeat <= 1'b0;
    else       r_repeat <= w_repeat_next;
  end
  assign o_repeat = r_repeat;
`else
  assign o_repeat = 1'b0;
`endif

  assign o_short_press  = r_short_press;
  assign o_double_click = r_double_click;
  assign o_long_press   = r_long_press;
  assign o_held_long    = (r_state == S_LONG_HELD);
  assign o_busy         = (r_state != S_IDLE);

endmodule

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Consumes the debounced push-button event interface (level `pb_state`, one-cycle `pb_down` / `pb_up` pulses) and classifies user gestures.
- Gestures: short press, double click, long press, plus optional auto-repeat while held.
- Sits between the debouncer and the counter control logic; timing is driven by an external one-cycle `tick` enable from the shared prescaler.

Parameters:
- LONG_TICKS, 500, ticks a press must last to count as a long press; must be >= 2.
- DCLICK_TICKS, 250, ticks after release in which a second press makes a double click; must be >= 1.
- REPEAT_TICKS, 100, ticks between auto-repeat pulses while long-held; must be >= 1; used only with AUTO_REPEAT_EN.
- CNT_W, 16, tick counter width; must hold max(LONG_TICKS, DCLICK_TICKS, REPEAT_TICKS).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timing enable.
- pb_state  in  1  debounced button level, 1 = held; used for consistency only.
- pb_down  in  1  one-cycle pulse, button pressed.
- pb_up  in  1  one-cycle pulse, button released.
- short_press  out  1  one-cycle pulse, single short press confirmed.
- double_click  out  1  one-cycle pulse, double click confirmed.
- long_press  out  1  one-cycle pulse, long-press threshold reached.
- repeat  out  1  one-cycle pulse, auto-repeat.
- held_long  out  1  level, 1 while in LONG_HELD.
- busy  out  1  level, 1 whenever the FSM is not in IDLE.

Behaviour:
- Reset: rst=1 asynchronously forces state IDLE and counter 0; all outputs are 0. Reset mid-gesture discards the gesture with no event. After rst deasserts, a button already held is ignored until the next pb_down.
- Outputs are registered. An event pulse is high for exactly one clk cycle, in the cycle after the edge at which its condition was sampled.
- Counter cnt (CNT_W bits) is cleared on every state change. It increments only on cycles with tick=1 and never wraps; every threshold exits or reloads first.
- IDLE: pb_down -> PRESSED.
- PRESSED:
  - pb_up -> WAIT_SECOND.
  - Otherwise, tick with cnt==LONG_TICKS-1 -> pulse long_press, go to LONG_HELD.
  - If pb_up and the threshold tick coincide, pb_up wins (release path, no long_press).
- WAIT_SECOND:
  - pb_down -> SECOND_PRESSED.
  - Otherwise, tick with cnt==DCLICK_TICKS-1 -> pulse short_press, go to IDLE.
  - If pb_down and the timeout tick coincide, pb_down wins.
- SECOND_PRESSED:
  - pb_up -> pulse double_click, go to IDLE.
  - Otherwise, tick with cnt==LONG_TICKS-1 -> pulse long_press, go to LONG_HELD. No double_click is emitted on this path.
- LONG_HELD: pb_up -> IDLE with no pulse. held_long=1 only in this state.
- Protocol errors, all ignored with no state change and no event:
  - pb_down and pb_up asserted in the same cycle.
  - pb_down while already pressed.
  - pb_up in IDLE or WAIT_SECOND.
- Consistency check: in PRESSED, SECOND_PRESSED or LONG_HELD, if pb_state==0 for a cycle with no pb_up pulse (a lost pulse), go to IDLE silently.
- At most one event pulse is high in any cycle.

Optional Feature:
- AUTO_REPEAT_EN defined:
  - On entry to LONG_HELD, cnt=0.
  - Each tick with cnt==REPEAT_TICKS-1 pulses repeat and reloads cnt=0.
  - The first repeat comes REPEAT_TICKS ticks after long_press, then every REPEAT_TICKS ticks until pb_up.
  - pb_up coinciding with a repeat tick: pb_up wins, no repeat.
- Not defined: the repeat port exists but is tied 0, and the LONG_HELD counter logic is absent.

Test Plan:
Parameters for all scenarios: LONG_TICKS=8, DCLICK_TICKS=4, REPEAT_TICKS=3, tick=1 every cycle.
- Short press: pb_down, pb_up 3 cycles later, no further press -> short_press single pulse 4 ticks after pb_up. No other events.
- Double click: press 2 cycles, release, pb_down 2 cycles after release, release 2 cycles later -> double_click 1 cycle after the second pb_up. No short_press.
- Long press: pb_down held 20 cycles -> long_press 1 cycle after the 8th tick. held_long=1 until 1 cycle after pb_up. With AUTO_REPEAT_EN, repeat pulses every 3 ticks after long_press, 4 pulses before release.
- Coincidence: pb_up on the same cycle as the 8th tick -> no long_press; short_press follows 4 ticks later. pb_down on the 4th WAIT_SECOND tick -> no short_press, enters SECOND_PRESSED.
- Reset mid-gesture: assert rst 5 cycles into PRESSED -> all outputs 0 immediately (async). After release of rst, no event is emitted for that press; the next press classifies normally.
- Protocol error: pb_down and pb_up together in IDLE -> busy stays 0, no pulses. pb_state dropped to 0 in PRESSED with no pb_up -> IDLE next cycle, no events.
